fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 8 +
 rtl/fetch_unit_fifo.sv | 57 +++++
 rtl/fetch_unit.sv | 85 ++++++++
 tb/tb_fetch_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared RISC-V fetch definitions: datapath width, instruction width, PC step.
package fetch_unit_pkg;

   localparam int XLEN_DEFAULT = 32;
   localparam int ILEN         = 32;
   localparam int INSTR_BYTES  = 4;

endpackage

// File: rtl/fetch_unit_fifo.sv
// Circular instruction buffer holding {pc, instr} entries; flush empties it in one cycle.
module fetch_fifo
   import fetch_unit_pkg::*;
#(
   parameter int WIDTH = XLEN_DEFAULT + ILEN,
   parameter int DEPTH = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    push,
   input  logic                    pop,
   input  logic                    flush,
   input  logic [WIDTH-1:0]        wdata,
   output logic [WIDTH-1:0]        rdata,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_W = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage has no reset; the count gates what is visible, so stale contents never leak out.
   always_ff @(posedge clock) begin
      if (push && !flush) mem[wr_ptr] <= wdata;
   end

   assign empty = (count == '0);
   assign full  = (count == DEPTH_W);
   assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: one-cycle synchronous imem, one request in flight, FIFO to decode.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEFAULT,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                    clock,
   input  logic                    reset,
   output logic                    imem_req,
   output logic [XLEN-1:0]         imem_addr,
   input  logic [ILEN-1:0]         imem_rdata,
   input  logic                    redirect_valid,
   input  logic [XLEN-1:0]         redirect_pc,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [ILEN-1:0]         out_instr,
   output logic [XLEN-1:0]         out_pc,
   output logic [$clog2(DEPTH):0]  occupancy
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   logic [XLEN-1:0]      fetch_pc;
   logic [XLEN-1:0]      inflight_pc;
   logic                 inflight;
   logic [XLEN-1:0]      redirect_addr;
   logic                 push;
   logic                 pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [CW:0]          demand;
   logic [XLEN+ILEN-1:0] fifo_rdata;

   assign redirect_addr = redirect_pc & ~XLEN'(3);
   assign out_valid     = !fifo_empty && !redirect_valid;
   assign pop           = out_valid && out_ready;
   // A redirect kills the returning word: it belongs to the abandoned path.
   assign push          = inflight && !redirect_valid;

   // Entries already owned plus the one still coming back must leave room for a new one.
   assign demand   = {1'b0, occupancy} + (CW+1)'(inflight) - (CW+1)'(pop);
   assign imem_req = reset && (redirect_valid || (demand < DEPTH_W));
   assign imem_addr = redirect_valid ? redirect_addr : fetch_pc;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fetch_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else begin
         inflight <= imem_req;
         if (imem_req) begin
            inflight_pc <= imem_addr;
            fetch_pc    <= imem_addr + XLEN'(INSTR_BYTES);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) assert (!(push && fifo_full && !pop));
   end

   fetch_fifo #(
      .WIDTH (XLEN + ILEN),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .wdata ({inflight_pc, imem_rdata}),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (occupancy)
   );

   assign out_pc    = fifo_rdata[XLEN+ILEN-1:ILEN];
   assign out_instr = fifo_rdata[ILEN-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle-by-cycle vector table plus reset-with-full-buffer sequence.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [2:0]  occupancy;

   int checks   = 0;
   int failures = 0;

   fetch_unit #(
      .XLEN     (32),
      .DEPTH    (4),
      .RESET_PC (32'h0000_0100)
   ) dut (
      .clock          (clk),
      .reset          (reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .occupancy      (occupancy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   // Synchronous-read instruction memory with one cycle of latency.
   always @(posedge clk) begin
      if (imem_req) imem_rdata <= instr_of(imem_addr);
      else          imem_rdata <= 32'hBAD0_BAD0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        rv;
      logic [31:0] rpc;
      logic        rdy;
      logic        req;
      logic [31:0] addr;
      logic        vld;
      logic [31:0] pc;
      logic [2:0]  occ;
   } vec_t;

   vec_t vecs[24];

   function automatic vec_t v(input logic rv, input logic [31:0] rpc, input logic rdy,
                              input logic req, input logic [31:0] addr,
                              input logic vld, input logic [31:0] pc, input logic [2:0] occ);
      vec_t r;
      r.rv = rv; r.rpc = rpc; r.rdy = rdy; r.req = req; r.addr = addr;
      r.vld = vld; r.pc = pc; r.occ = occ;
      return r;
   endfunction

   initial begin
      // release, streaming
      vecs[0]  = v(0, 0, 1, 1, 32'h100, 0, 0, 0);
      vecs[1]  = v(0, 0, 1, 1, 32'h104, 0, 0, 0);
      vecs[2]  = v(0, 0, 1, 1, 32'h108, 1, 32'h100, 1);
      vecs[3]  = v(0, 0, 1, 1, 32'h10C, 1, 32'h104, 1);
      // backpressure: fills to 4 then requests stop, head stays put
      vecs[4]  = v(0, 0, 0, 1, 32'h110, 1, 32'h108, 1);
      vecs[5]  = v(0, 0, 0, 1, 32'h114, 1, 32'h108, 2);
      vecs[6]  = v(0, 0, 0, 0, 0,       1, 32'h108, 3);
      vecs[7]  = v(0, 0, 0, 0, 0,       1, 32'h108, 4);
      vecs[8]  = v(0, 0, 0, 0, 0,       1, 32'h108, 4);
      vecs[9]  = v(0, 0, 1, 1, 32'h118, 1, 32'h108, 4);
      vecs[10] = v(0, 0, 1, 1, 32'h11C, 1, 32'h10C, 3);
      vecs[11] = v(0, 0, 1, 1, 32'h120, 1, 32'h110, 3);
      // redirect with 3 buffered and 1 in flight
      vecs[12] = v(1, 32'h2000, 1, 1, 32'h2000, 0, 0, 3);
      vecs[13] = v(0, 0, 1, 1, 32'h2004, 0, 0, 0);
      vecs[14] = v(0, 0, 1, 1, 32'h2008, 1, 32'h2000, 1);
      vecs[15] = v(0, 0, 1, 1, 32'h200C, 1, 32'h2004, 1);
      // misaligned redirect target
      vecs[16] = v(1, 32'h2003, 1, 1, 32'h2000, 0, 0, 1);
      vecs[17] = v(0, 0, 1, 1, 32'h2004, 0, 0, 0);
      vecs[18] = v(0, 0, 1, 1, 32'h2008, 1, 32'h2000, 1);
      // PC wrap at the top of the address space
      vecs[19] = v(1, 32'hFFFF_FFFC, 1, 1, 32'hFFFF_FFFC, 0, 0, 1);
      vecs[20] = v(0, 0, 1, 1, 32'h0,   0, 0, 0);
      vecs[21] = v(0, 0, 1, 1, 32'h4,   1, 32'hFFFF_FFFC, 1);
      vecs[22] = v(0, 0, 1, 1, 32'h8,   1, 32'h0, 1);
      vecs[23] = v(0, 0, 1, 1, 32'hC,   1, 32'h4, 1);

      reset          = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h3000;
      out_ready      = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("reset req",   32'(imem_req),  0);
      check("reset valid", 32'(out_valid), 0);
      check("reset occ",   32'(occupancy), 0);
      check("reset pc",    out_pc,         0);
      check("reset instr", out_instr,      0);

      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         if (i == 0) reset = 1'b1;
         redirect_valid = vecs[i].rv;
         redirect_pc    = vecs[i].rpc;
         out_ready      = vecs[i].rdy;
         #1;
         check($sformatf("c%0d req", i),   32'(imem_req),  32'(vecs[i].req));
         if (vecs[i].req)
            check($sformatf("c%0d addr", i), imem_addr, vecs[i].addr);
         check($sformatf("c%0d valid", i), 32'(out_valid), 32'(vecs[i].vld));
         if (vecs[i].vld) begin
            check($sformatf("c%0d pc", i),    out_pc,    vecs[i].pc);
            check($sformatf("c%0d instr", i), out_instr, instr_of(vecs[i].pc));
         end
         check($sformatf("c%0d occ", i), 32'(occupancy), 32'(vecs[i].occ));
      end

      // Fill the buffer, then assert reset mid-operation.
      @(negedge clk);
      redirect_valid = 1'b0;
      out_ready      = 1'b0;
      begin
         int budget = 20;
         #1;
         while (occupancy != 3'd4 && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
         end
         check("fill occ", 32'(occupancy), 4);
         check("fill req", 32'(imem_req),  0);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("mid reset valid", 32'(out_valid), 0);
      check("mid reset req",   32'(imem_req),  0);
      check("mid reset occ",   32'(occupancy), 0);
      @(negedge clk);
      reset     = 1'b1;
      out_ready = 1'b1;
      #1;
      check("restart addr0", imem_addr, 32'h100);
      @(negedge clk);
      #1;
      check("restart addr1",  imem_addr, 32'h104);
      check("restart valid1", 32'(out_valid), 0);
      @(negedge clk);
      #1;
      check("restart valid2", 32'(out_valid), 1);
      check("restart pc2",    out_pc, 32'h100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
